// File: rtl/mem_bank_resp.sv
// Banked byte-lane memory responder with one-cycle registered read and a byte loader port.
// Define MEM_BANK_CLEAR_EN to build in the post-reset array clear sequencer.
module mem_bank_resp #(
  parameter int M_WIDTH    = 32,
  parameter int DEPTH_LOG2 = 8,
  localparam int NB        = M_WIDTH / 8,
  localparam int BS        = $clog2(NB),
  localparam int AW        = M_WIDTH - BS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW-1:0]            mem_addr,
  input  logic [NB-1:0]            mem_we,
  input  logic [M_WIDTH-1:0]       mem_wdata,
  output logic [M_WIDTH-1:0]       mem_rdata,
  input  logic                     ld_valid,
  input  logic [DEPTH_LOG2+BS-1:0] ld_addr,
  input  logic [7:0]               ld_data,
  output logic                     ld_ready,
  output logic                     init_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            bank [NB][DEPTH];
  logic [DEPTH_LOG2-1:0] word;
  logic [DEPTH_LOG2-1:0] ld_word;
  logic [BS-1:0]         ld_lane;
  logic                  serve;
  logic                  ld_fire;
  logic                  unused_addr_hi;

  logic [NB-1:0]         wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr [NB];
  logic [7:0]            wr_data [NB];
  logic [M_WIDTH-1:0]    rdata_p0;

  assign word           = mem_addr[DEPTH_LOG2-1:0];
  assign ld_lane        = ld_addr[BS-1:0];
  assign ld_word        = ld_addr[DEPTH_LOG2+BS-1:BS];
  assign unused_addr_hi = ^mem_addr[AW-1:DEPTH_LOG2];

  // The port owns the array whenever it drives any lane; the loader only gets idle cycles.
  assign serve    = rst && !init_busy;
  assign ld_ready = serve && (mem_we == '0);
  assign ld_fire  = ld_valid && ld_ready;

`ifdef MEM_BANK_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [DEPTH_LOG2-1:0] LAST_WORD = DEPTH_LOG2'(DEPTH - 1);

  state_t                state;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic                  busy_q;
  logic                  clr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_WORD) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          clr_cnt <= clr_cnt;
        end
        default: begin
          state  <= CLEAR;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign init_busy = busy_q;
  assign clr_en    = rst && (state == CLEAR);
`else
  assign init_busy = 1'b0;
`endif

  // Per-lane write port selection: clear, then port, then loader.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      wr_en[i]   = 1'b0;
      wr_addr[i] = word;
      wr_data[i] = mem_wdata[8*i +: 8];
`ifdef MEM_BANK_CLEAR_EN
      if (clr_en) begin
        wr_en[i]   = 1'b1;
        wr_addr[i] = clr_cnt;
        wr_data[i] = 8'h00;
      end else
`endif
      if (serve && mem_we[i]) begin
        wr_en[i] = 1'b1;
      end else if (ld_fire && (ld_lane == BS'(i))) begin
        wr_en[i]   = 1'b1;
        wr_addr[i] = ld_word;
        wr_data[i] = ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_en[i]) bank[i][wr_addr[i]] <= wr_data[i];
    end
  end

  // Read bypass: any lane written at the read word this edge returns the new byte.
  always_comb begin
    rdata_p0 = '0;
    for (int i = 0; i < NB; i++) begin
      if (!serve)
        rdata_p0[8*i +: 8] = 8'h00;
      else if (mem_we[i])
        rdata_p0[8*i +: 8] = mem_wdata[8*i +: 8];
      else if (ld_fire && (ld_lane == BS'(i)) && (ld_word == word))
        rdata_p0[8*i +: 8] = ld_data;
      else
        rdata_p0[8*i +: 8] = bank[i][word];
    end
  end

  // Stage p1: registered read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_rdata <= '0;
    else      mem_rdata <= rdata_p0;
  end

endmodule

// File: tb/tb_mem_bank_resp.sv
// Self-checking bench for mem_bank_resp (M_WIDTH=32, DEPTH_LOG2=4) against a byte-array model.
// Adapts its clear/reset expectations to whether MEM_BANK_CLEAR_EN is defined.
module tb_mem_bank_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        ld_valid;
  logic [5:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        init_busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] model [64];

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  mem_bank_resp #(.M_WIDTH(32), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model_word(input int w);
    return {model[w*4+3], model[w*4+2], model[w*4+1], model[w*4]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic port_op(input logic [29:0] a, input logic [3:0] w, input logic [31:0] d);
    mem_addr  = a;
    mem_we    = w;
    mem_wdata = d;
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      if (w[i]) model[int'(a[3:0])*4+i] = d[8*i +: 8];
    @(negedge clk);
  endtask

  task automatic read_all(input string name);
    for (int w = 0; w < 16; w++) begin
      port_op(30'(w), 4'h0, 32'h0);
      check($sformatf("%s_w%0d", name, w), mem_rdata, model_word(w));
    end
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    mem_we    = 4'hF;
    mem_wdata = 32'hFFFF_FFFF;
    ld_valid  = 1'b1;
    for (int k = 0; k < 100 && init_busy; k++) begin
      n++;
      #1;
      check({name, "_rdata0"}, mem_rdata, 32'h0);
      check({name, "_ldrdy0"}, 32'(ld_ready), 32'h0);
      @(negedge clk);
    end
    mem_we   = 4'h0;
    ld_valid = 1'b0;
    check({name, "_len"}, 32'(n), 32'd16);
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
  endtask

  initial begin
    logic [3:0] w;
    logic       exp_rdy;

    tbl[0] = '{30'h5,        4'hF, 32'hAABBCCDD, 32'hAABBCCDD};
    tbl[1] = '{30'h5,        4'h5, 32'h11223344, 32'hAA22CC44};
    tbl[2] = '{30'h5,        4'h0, 32'h00000000, 32'hAA22CC44};
    tbl[3] = '{30'h7,        4'hF, 32'h01020304, 32'h01020304};
    tbl[4] = '{30'h7,        4'h2, 32'hFFFFEEFF, 32'h0102EE04};
    tbl[5] = '{30'h7,        4'h0, 32'h00000000, 32'h0102EE04};
    tbl[6] = '{30'h12,       4'hF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[7] = '{30'h02,       4'h0, 32'h00000000, 32'hDEADBEEF};
    tbl[8] = '{30'h3FFFFFF5, 4'h0, 32'h00000000, 32'hAA22CC44};
    tbl[9] = '{30'h5,        4'h8, 32'h77000000, 32'h7722CC44};

    rst = 1'b0; mem_addr = '0; mem_we = '0; mem_wdata = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_ld_ready", 32'(ld_ready), 32'h0);
`ifdef MEM_BANK_CLEAR_EN
    check("rst_busy", 32'(init_busy), 32'h1);
    rst = 1'b1;
    count_clear("clear1");
    read_all("clr1_read");
`else
    check("rst_busy", 32'(init_busy), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) port_op(30'(i), 4'hF, $urandom);
    read_all("init_read");
`endif

    for (int i = 0; i < 10; i++) begin
      port_op(tbl[i].addr, tbl[i].we, tbl[i].wdata);
      check($sformatf("vec%0d", i), mem_rdata, tbl[i].exp);
    end

    // Loader held off by port writes for two cycles, accepted in the third.
    ld_valid = 1'b1; ld_addr = 6'h1B; ld_data = 8'h5A;
    for (int c = 0; c < 2; c++) begin
      mem_addr = 30'h9; mem_we = 4'h1; mem_wdata = $urandom;
      #1;
      check($sformatf("ld_block%0d", c), 32'(ld_ready), 32'h0);
      port_op(mem_addr, mem_we, mem_wdata);
    end
    mem_addr = 30'h6; mem_we = 4'h0;
    #1;
    check("ld_accept", 32'(ld_ready), 32'h1);
    @(posedge clk);
    model[6*4+3] = 8'h5A;
    @(negedge clk);
    check("ld_bypass", mem_rdata, model_word(6));
    ld_valid = 1'b0;
    port_op(30'h6, 4'h0, 32'h0);
    check("ld_lane3", 32'(mem_rdata[31:24]), 32'h5A);
    check("ld_word6", mem_rdata, model_word(6));
    port_op(30'h9, 4'h0, 32'h0);
    check("ld_port_word9", mem_rdata, model_word(9));

    // Randomized traffic against the byte model.
    for (int c = 0; c < 400; c++) begin
      w         = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      mem_addr  = {26'($urandom), 4'($urandom_range(0, 15))};
      mem_we    = w;
      mem_wdata = $urandom;
      ld_valid  = 1'($urandom_range(0, 1));
      ld_addr   = 6'($urandom_range(0, 63));
      ld_data   = 8'($urandom);
      exp_rdy   = (w == 4'h0);
      #1;
      check("rnd_ld_ready", 32'(ld_ready), 32'(exp_rdy));
      @(posedge clk);
      for (int i = 0; i < 4; i++)
        if (w[i]) model[int'(mem_addr[3:0])*4+i] = mem_wdata[8*i +: 8];
      if (ld_valid && exp_rdy) model[ld_addr] = ld_data;
      @(negedge clk);
      check("rnd_rdata", mem_rdata, model_word(int'(mem_addr[3:0])));
    end
    ld_valid = 1'b0; mem_we = 4'h0;
    read_all("rnd_read");

    // Reset in the middle of activity, with a loader byte pending.
`ifdef MEM_BANK_CLEAR_EN
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (9) @(negedge clk);
    check("midclr_busy_pre", 32'(init_busy), 32'h1);
    rst = 1'b0; ld_valid = 1'b1;
    #1;
    check("midrst_rdata", mem_rdata, 32'h0);
    check("midrst_ld_ready", 32'(ld_ready), 32'h0);
    check("midrst_busy", 32'(init_busy), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    count_clear("clear2");
    read_all("clr2_read");
`else
    mem_addr = 30'h5; ld_valid = 1'b1; ld_addr = 6'h00; ld_data = ~model[0];
    rst = 1'b0;
    #1;
    check("midrst_rdata", mem_rdata, 32'h0);
    check("midrst_ld_ready", 32'(ld_ready), 32'h0);
    check("midrst_busy", 32'(init_busy), 32'h0);
    repeat (2) @(negedge clk);
    check("midrst_rdata_hold", mem_rdata, 32'h0);
    ld_valid = 1'b0;
    rst = 1'b1;
    read_all("survive_read");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bank_resp.md
# mem_bank_resp

Memory-side responder for the banked memory port of the memory interface: M_WIDTH/8 byte-wide banks with a word address, per-lane write enables, and registered one-cycle read data, which matches the fixed read timing the interface expects. A byte-wide loader port lets the test harness or boot logic preload program/data bytes. An optional post-reset clear sequencer zeroes the whole array before normal service begins.

## Interface

- M_WIDTH, 32, data width in bits; multiple of 8; bank count NB = M_WIDTH/8
- DEPTH_LOG2, 8, log2 of words per bank; DEPTH = 2**DEPTH_LOG2
- Derived: BS = $clog2(NB) (bank-select bits), AW = M_WIDTH-BS (word address width)

Ports:

- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- mem_addr  in  AW  word address; only bits [DEPTH_LOG2-1:0] are used, upper bits are ignored (address wraps)
- mem_we  in  NB  per-lane write enable; bit i writes byte lane i
- mem_wdata  in  M_WIDTH  write data; lane i = bits [8i+7:8i]
- mem_rdata  out  M_WIDTH  registered read data for the mem_addr of the previous cycle
- ld_valid  in  1  loader byte valid
- ld_addr  in  DEPTH_LOG2+BS  loader byte address; low BS bits select the lane, upper bits select the word
- ld_data  in  8  loader byte
- ld_ready  out  1  loader byte accepted this cycle when ld_valid && ld_ready
- init_busy  out  1  clear sequencer is running; port is not serviced

## Operation

- Storage: NB independent arrays of DEPTH bytes.
- Port write: on posedge, when not busy, every lane i with mem_we[i]=1 stores mem_wdata lane i at word mem_addr.
- Port read: on every posedge, mem_rdata <= word at mem_addr. This is write-first per lane: a lane written in the same cycle returns the new byte, and unwritten lanes return the old contents.
- Loader: ld_ready = !init_busy && (mem_we == 0). On handshake, lane ld_addr[BS-1:0] of word ld_addr[DEPTH_LOG2+BS-1:BS] <= ld_data.
  - The port always wins; a loader byte is held off and never dropped.
  - A loader write does not affect the mem_rdata registered in the same cycle unless the addresses match. When they match, the result is write-first, the same as for the port.
- Clear sequencer states (MEM_BANK_CLEAR_EN only):
  - CLEAR: counter c runs from 0 to DEPTH-1. Each cycle all lanes of word c <= 0. mem_we and the loader are ignored. mem_rdata <= 0.
  - RUN: normal service.
  - Transition CLEAR→RUN occurs after the write at c = DEPTH-1.
- Reset asserted (rst=0), at any time, including mid-clear or mid-load:
  - mem_rdata = 0, ld_ready = 0, counter = 0.
  - State = CLEAR (with the macro) or RUN (without it).
  - init_busy = 1 with the macro, 0 without it.

## Timing

- Read latency is exactly 1 cycle: the address presented in cycle N gives mem_rdata valid from the cycle N+1 edge until the next edge.
- Back-to-back reads at consecutive addresses yield one word per cycle.
- Write takes effect at the edge. A read of the same address in the next cycle returns the new data.
- Clear duration:
  - init_busy stays high for exactly DEPTH cycles after the first edge following rst release.
  - The first port access is serviced in the cycle in which init_busy is first sampled low.
- ld_ready is combinational from mem_we and init_busy. There is no loader latency beyond the write edge.

## Configuration

- MEM_BANK_CLEAR_EN defined: the clear sequencer is present. The array is all-zero after every reset, and init_busy behaves as above.
- MEM_BANK_CLEAR_EN undefined: no sequencer or counter. init_busy is tied to 0. Array contents are undefined after power-up and preserved across reset. Service starts at the first edge after rst release.

## Test plan

- Reset and clear (macro on, DEPTH_LOG2=4): release rst, then count cycles -> init_busy is 1 for exactly 16 cycles. After that, a read of every word returns 0x00000000, and mem_rdata is 0 throughout.
- Lane writes: write 0xAABBCCDD to word 5 with mem_we=4'b1111, then 0x11223344 with mem_we=4'b0101, then read word 5 -> 0xAA22CC44 one cycle after the address.
- Read-during-write: same cycle, address 7 holding 0x01020304, mem_we=4'b0010, wdata 0xFFFFEEFF -> that edge's mem_rdata = 0x0102EE04.
- Loader arbitration: ld_valid=1 to byte address 0x1B with data 0x5A while mem_we=4'b0001 for two cycles -> ld_ready is 0 for both cycles, the byte is accepted in cycle 3, and word 6 lane 3 reads 0x5A.
- Address wrap (DEPTH_LOG2=4): write 0xDEADBEEF at mem_addr 0x12, then read mem_addr 0x02 -> 0xDEADBEEF.
- Reset mid-clear: assert rst at clear cycle 9, then release -> init_busy runs a full 16 cycles again. With the macro off, previously written words survive the reset.
